// File: rtl/math_game_pkg.sv
// Shared types and constants for the math-game round sequencer.
// Holds the FSM state encoding, operation codes and timer limits.
package math_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_A   = 3'd1,
    S_FETCH_B   = 3'd2,
    S_ORDER     = 3'd3,
    S_WAIT_ANS  = 3'd4,
    S_JUDGE     = 3'd5,
    S_GAME_OVER = 3'd6
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned TIMER_W = 4;
  localparam logic [TIMER_W-1:0] RELOAD_MIN = 4'd3;

  // One step shorter per speed-up, never below the floor.
  function automatic logic [TIMER_W-1:0] reload_step_down(input logic [TIMER_W-1:0] cur);
    return (cur > RELOAD_MIN) ? cur - 4'd1 : RELOAD_MIN;
  endfunction

endpackage

// File: rtl/round_countdown.sv
// Per-round seconds countdown: load wins over tick, and expire flags the tick
// that would take the count from 1 to 0.
module round_countdown
  import math_game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               tick,
  input  logic [TIMER_W-1:0] reload,
  output logic [TIMER_W-1:0] timer_sec,
  output logic               expire
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_sec <= '0;
    end else if (load) begin
      timer_sec <= reload;
    end else if (tick && (timer_sec != '0)) begin
      timer_sec <= timer_sec - 4'd1;
    end
  end

  assign expire = tick && !load && (timer_sec == 4'd1);

endmodule

// File: rtl/game_round_sequencer.sv
// Math-game session sequencer: fetches two RNG operands, runs the round countdown,
// judges the answer and tracks score/lives. Optional macro STREAK_SPEEDUP_EN.
module game_round_sequencer
  import math_game_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ANS_W   = 5,
  parameter int unsigned TIME_S  = 10,
  parameter int unsigned LIVES   = 3,
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               op_sel,
  input  logic               no_borrow,
  input  logic               rng_ack,
  input  logic [OPW-1:0]     rng_data,
  input  logic               tick_1s,
  input  logic               answer_valid,
  input  logic [ANS_W-1:0]   answer,
  output logic               rng_req,
  output logic [OPW-1:0]     operand_a,
  output logic [OPW-1:0]     operand_b,
  output logic [3:0]         timer_sec,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               correct,
  output logic               wrong,
  output logic               busy,
  output logic               game_over
);

  state_e             state;
  logic [ANS_W-1:0]   expected;
  logic [TIMER_W-1:0] reload;
  logic               cd_load;
  logic               cd_tick;
  logic               cd_expire;

  logic               do_swap;
  logic [OPW-1:0]     ord_a;
  logic [OPW-1:0]     ord_b;
  logic [ANS_W-1:0]   exp_next;
  logic               answer_ok;
  logic [SCORE_W-1:0] score_inc;
  logic [2:0]         lives_dec;

  assign cd_load = (state == S_ORDER);
  assign cd_tick = tick_1s && (state == S_WAIT_ANS);

  round_countdown u_round_countdown (
    .clk       (clk),
    .rst       (rst),
    .load      (cd_load),
    .tick      (cd_tick),
    .reload    (reload),
    .timer_sec (timer_sec),
    .expire    (cd_expire)
  );

  always_comb begin
    do_swap  = (op_sel == OP_SUB) && no_borrow && (operand_a < operand_b);
    ord_a    = do_swap ? operand_b : operand_a;
    ord_b    = do_swap ? operand_a : operand_b;
    exp_next = (op_sel == OP_SUB) ? (ANS_W'(ord_a) - ANS_W'(ord_b))
                                  : (ANS_W'(ord_a) + ANS_W'(ord_b));
  end

  assign answer_ok = (answer == expected);
  assign score_inc = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
  assign lives_dec = lives - 3'd1;

`ifdef STREAK_SPEEDUP_EN
  logic [2:0]         streak;
  logic [2:0]         streak_inc;
  logic [TIMER_W-1:0] reload_q;
  logic               judge_fire;
  logic               judge_right;
  logic               start_ok;

  assign streak_inc  = streak + 3'd1;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_GAME_OVER));
  assign judge_fire  = (state == S_WAIT_ANS) && (answer_valid || cd_expire);
  assign judge_right = answer_valid && answer_ok;

  // Counter wraps at 8, so its low two bits hitting zero marks every 4th in a row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak   <= '0;
      reload_q <= TIMER_W'(TIME_S);
    end else if (!abort) begin
      if (start_ok) begin
        reload_q <= TIMER_W'(TIME_S);
      end else if (judge_fire) begin
        if (judge_right) begin
          streak <= streak_inc;
          if (streak_inc[1:0] == 2'b00) begin
            reload_q <= reload_step_down(reload_q);
          end
        end else begin
          streak   <= '0;
          reload_q <= TIMER_W'(TIME_S);
        end
      end
    end
  end

  assign reload = reload_q;
`else
  assign reload = TIMER_W'(TIME_S);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      rng_req   <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      expected  <= '0;
      score     <= '0;
      lives     <= '0;
      correct   <= 1'b0;
      wrong     <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      correct <= 1'b0;
      wrong   <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        rng_req   <= 1'b0;
        busy      <= 1'b0;
        game_over <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_GAME_OVER: begin
            if (start) begin
              score     <= '0;
              lives     <= 3'(LIVES);
              state     <= S_FETCH_A;
              rng_req   <= 1'b1;
              busy      <= 1'b1;
              game_over <= 1'b0;
            end
          end
          // rng_req low inside a fetch state means the operand is already captured.
          S_FETCH_A: begin
            if (rng_req) begin
              if (rng_ack) begin
                operand_a <= rng_data;
                rng_req   <= 1'b0;
              end
            end else begin
              state   <= S_FETCH_B;
              rng_req <= 1'b1;
            end
          end
          S_FETCH_B: begin
            if (rng_req) begin
              if (rng_ack) begin
                operand_b <= rng_data;
                rng_req   <= 1'b0;
              end
            end else begin
              state <= S_ORDER;
            end
          end
          S_ORDER: begin
            operand_a <= ord_a;
            operand_b <= ord_b;
            expected  <= exp_next;
            state     <= S_WAIT_ANS;
          end
          S_WAIT_ANS: begin
            if (answer_valid) begin
              state <= S_JUDGE;
              if (answer_ok) begin
                correct <= 1'b1;
                score   <= score_inc;
              end else begin
                wrong <= 1'b1;
                lives <= lives_dec;
              end
            end else if (cd_expire) begin
              state <= S_JUDGE;
              wrong <= 1'b1;
              lives <= lives_dec;
            end
          end
          S_JUDGE: begin
            if (lives == 3'd0) begin
              state     <= S_GAME_OVER;
              busy      <= 1'b0;
              game_over <= 1'b1;
            end else begin
              state   <= S_FETCH_A;
              rng_req <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: directed scenarios plus randomized
// rounds against a score/lives/reload model. Honours STREAK_SPEEDUP_EN.
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       op_sel = 1'b0;
  logic       no_borrow = 1'b0;
  logic       rng_ack = 1'b0;
  logic [3:0] rng_data = 4'd0;
  logic       tick_1s = 1'b0;
  logic       answer_valid = 1'b0;
  logic [4:0] answer = 5'd0;
  logic       rng_req;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic [3:0] timer_sec;
  logic [7:0] score;
  logic [2:0] lives;
  logic       correct;
  logic       wrong;
  logic       busy;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  int m_score = 0;
  int m_lives = 0;
  int m_reload = 10;
  int m_streak = 0;

  game_round_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .op_sel       (op_sel),
    .no_borrow    (no_borrow),
    .rng_ack      (rng_ack),
    .rng_data     (rng_data),
    .tick_1s      (tick_1s),
    .answer_valid (answer_valid),
    .answer       (answer),
    .rng_req      (rng_req),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .timer_sec    (timer_sec),
    .score        (score),
    .lives        (lives),
    .correct      (correct),
    .wrong        (wrong),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: the displayed pair and expected result of a round.
  function automatic void ref_round(input int a, input int b, input bit op, input bit nb,
                                    output int oa, output int ob, output int ex);
    oa = a;
    ob = b;
    if (op && nb && (a < b)) begin
      oa = b;
      ob = a;
    end
    ex = op ? (((oa - ob) + 32) % 32) : (oa + ob);
  endfunction

  function automatic void model_start();
    m_score  = 0;
    m_lives  = 3;
    m_reload = 10;
  endfunction

  function automatic void model_judge(input bit right);
    if (right) begin
      if (m_score < 255) m_score = m_score + 1;
`ifdef STREAK_SPEEDUP_EN
      m_streak = m_streak + 1;
      if ((m_streak % 4) == 0 && m_reload > 3) m_reload = m_reload - 1;
`endif
    end else begin
      m_lives  = m_lives - 1;
      m_streak = 0;
      m_reload = 10;
    end
  endfunction

  task automatic serve_operand(input int val, input int gap, output bit ok);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rng_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    ok = 1'b0;
    if (found) begin
      repeat (gap) @(negedge clk);
      rng_data = 4'(val);
      rng_ack  = 1'b1;
      @(negedge clk);
      rng_ack  = 1'b0;
      rng_data = 4'($urandom);
      ok = (rng_req === 1'b0);
    end
  endtask

  // Returns at the first sample point inside WAIT_ANS.
  task automatic play_round(input int a, input int b, input int ga, input int gb,
                            input bit stray, output bit ok);
    bit ok_a;
    bit ok_b;
    serve_operand(a, ga, ok_a);
    if (stray) begin
      rng_data = 4'((a + 1) % 16);
      rng_ack  = 1'b1;
      @(negedge clk);
      rng_ack  = 1'b0;
    end
    serve_operand(b, gb, ok_b);
    repeat (2) @(negedge clk);
    ok = ok_a && ok_b;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      @(negedge clk);
      tick_1s = 1'b0;
      if (i < n - 1) repeat ($urandom % 2) @(negedge clk);
    end
  endtask

  task automatic submit(input int v);
    answer       = 5'(v);
    answer_valid = 1'b1;
    @(negedge clk);
    answer_valid = 1'b0;
    answer       = 5'($urandom);
  endtask

  task automatic session_begin();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rng_req, operand_a, operand_b, timer_sec, score, lives} !== 27'd0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0",
               {rng_req, operand_a, operand_b, timer_sec, score, lives});
    end
    checks++;
    if ({correct, wrong, busy, game_over} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {correct, wrong, busy, game_over});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    bit ok;
    op_sel = 1'b0;
    no_borrow = 1'b0;
    session_begin();
    checks++;
    if (busy !== 1'b1 || lives !== 3'd3 || score !== 8'd0) begin
      failures++;
      $display("FAIL start_state: busy=%b lives=%0d score=%0d want 1/3/0", busy, lives, score);
    end
    play_round(7, 5, 0, 0, 1'b0, ok);
    checks++;
    if (!ok || operand_a !== 4'd7 || operand_b !== 4'd5 || timer_sec !== 4'd10) begin
      failures++;
      $display("FAIL add_round: ok=%b a=%0d b=%0d t=%0d want 1/7/5/10",
               ok, operand_a, operand_b, timer_sec);
    end
    submit(12);
    model_judge(1'b1);
    checks++;
    if (correct !== 1'b1 || wrong !== 1'b0 || score !== 8'd1 || lives !== 3'd3) begin
      failures++;
      $display("FAIL add_judge: c=%b w=%b score=%0d lives=%0d want 1/0/1/3",
               correct, wrong, score, lives);
    end
  endtask

  task automatic test_sub_swap();
    bit ok;
    op_sel = 1'b1;
    no_borrow = 1'b1;
    play_round(3, 9, 1, 2, 1'b1, ok);
    checks++;
    if (!ok || operand_a !== 4'd9 || operand_b !== 4'd3) begin
      failures++;
      $display("FAIL swap_operands: ok=%b a=%0d b=%0d want 1/9/3", ok, operand_a, operand_b);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (score !== 8'd1 || lives !== 3'd3 || busy !== 1'b1 || timer_sec !== 4'd10) begin
      failures++;
      $display("FAIL start_ignored: score=%0d lives=%0d busy=%b t=%0d want 1/3/1/10",
               score, lives, busy, timer_sec);
    end
    submit(6);
    model_judge(1'b1);
    checks++;
    if (correct !== 1'b1 || score !== 8'd2) begin
      failures++;
      $display("FAIL swap_judge: c=%b score=%0d want 1/2", correct, score);
    end
  endtask

  task automatic test_sub_wrap();
    bit ok;
    submit(26);
    checks++;
    if (correct !== 1'b0 || wrong !== 1'b0 || score !== 8'd2) begin
      failures++;
      $display("FAIL answer_outside_wait: c=%b w=%b score=%0d want 0/0/2", correct, wrong, score);
    end
    op_sel = 1'b1;
    no_borrow = 1'b0;
    play_round(3, 9, 0, 0, 1'b0, ok);
    checks++;
    if (!ok || operand_a !== 4'd3 || operand_b !== 4'd9) begin
      failures++;
      $display("FAIL wrap_operands: ok=%b a=%0d b=%0d want 1/3/9", ok, operand_a, operand_b);
    end
    submit(26);
    model_judge(1'b1);
    checks++;
    if (correct !== 1'b1 || wrong !== 1'b0 || score !== 8'd3) begin
      failures++;
      $display("FAIL wrap_judge: c=%b w=%b score=%0d want 1/0/3", correct, wrong, score);
    end
  endtask

  task automatic test_timeout_game_over();
    bit ok;
    for (int r = 0; r < 3; r++) begin
      op_sel = 1'($urandom);
      play_round($urandom % 16, $urandom % 16, 0, 1, 1'b0, ok);
      do_ticks(m_reload - 1);
      checks++;
      if (!ok || timer_sec !== 4'd1 || wrong !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early r%0d: ok=%b t=%0d w=%b want 1/1/0", r, ok, timer_sec, wrong);
      end
      do_ticks(1);
      model_judge(1'b0);
      checks++;
      if (wrong !== 1'b1 || correct !== 1'b0 || lives !== 3'(m_lives)) begin
        failures++;
        $display("FAIL timeout_judge r%0d: w=%b c=%b lives=%0d want 1/0/%0d",
                 r, wrong, correct, lives, m_lives);
      end
    end
    @(negedge clk);
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0 || lives !== 3'd0 || rng_req !== 1'b0) begin
      failures++;
      $display("FAIL game_over: go=%b busy=%b lives=%0d req=%b want 1/0/0/0",
               game_over, busy, lives, rng_req);
    end
  endtask

  task automatic test_answer_beats_timeout();
    bit ok;
    int oa;
    int ob;
    int ex;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
    checks++;
    if (game_over !== 1'b0 || busy !== 1'b1 || score !== 8'd0 || lives !== 3'd3) begin
      failures++;
      $display("FAIL restart: go=%b busy=%b score=%0d lives=%0d want 0/1/0/3",
               game_over, busy, score, lives);
    end
    op_sel = 1'b0;
    play_round(11, 4, 0, 0, 1'b0, ok);
    ref_round(11, 4, 1'b0, 1'b0, oa, ob, ex);
    do_ticks(m_reload - 1);
    tick_1s = 1'b1;
    submit(ex);
    tick_1s = 1'b0;
    model_judge(1'b1);
    checks++;
    if (!ok || correct !== 1'b1 || wrong !== 1'b0 || lives !== 3'd3 || score !== 8'd1) begin
      failures++;
      $display("FAIL answer_vs_timeout: ok=%b c=%b w=%b lives=%0d score=%0d want 1/1/0/3/1",
               ok, correct, wrong, lives, score);
    end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rng_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!found || rng_req !== 1'b0 || busy !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL abort: found=%b req=%b busy=%b go=%b want 1/0/0/0",
               found, rng_req, busy, game_over);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (score !== 8'(m_score) || lives !== 3'(m_lives) || rng_req !== 1'b0 ||
        correct !== 1'b0 || wrong !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: score=%0d lives=%0d req=%b c=%b w=%b want %0d/%0d/0/0/0",
               score, lives, rng_req, correct, wrong, m_score, m_lives);
    end
  endtask

`ifdef STREAK_SPEEDUP_EN
  task automatic test_streak();
    bit ok;
    int oa;
    int ob;
    int ex;
    m_streak = 0;
    op_sel = 1'b0;
    session_begin();
    // Break any carried-over streak with one miss.
    play_round(1, 1, 0, 0, 1'b0, ok);
    submit(0);
    model_judge(1'b0);
    for (int r = 0; r < 4; r++) begin
      play_round(r, r + 2, 0, 0, 1'b0, ok);
      ref_round(r, r + 2, 1'b0, 1'b0, oa, ob, ex);
      submit(ex);
      model_judge(1'b1);
    end
    play_round(2, 2, 0, 0, 1'b0, ok);
    checks++;
    if (!ok || timer_sec !== 4'd9) begin
      failures++;
      $display("FAIL streak_reload: ok=%b t=%0d want 1/9", ok, timer_sec);
    end
    submit(5);
    model_judge(1'b0);
    play_round(2, 2, 0, 0, 1'b0, ok);
    checks++;
    if (timer_sec !== 4'd10) begin
      failures++;
      $display("FAIL streak_restore: t=%0d want 10", timer_sec);
    end
    submit(4);
    model_judge(1'b1);
  endtask
`endif

  task automatic test_random();
    bit ok;
    bit op;
    bit nb;
    bit right;
    int a;
    int b;
    int oa;
    int ob;
    int ex;
    int mode;
    int ans;
    session_begin();
    for (int r = 0; r < 40; r++) begin
      a  = $urandom % 16;
      b  = $urandom % 16;
      op = 1'($urandom);
      nb = 1'($urandom);
      op_sel    = op;
      no_borrow = nb;
      play_round(a, b, $urandom % 3, $urandom % 3, 1'($urandom), ok);
      ref_round(a, b, op, nb, oa, ob, ex);
      checks++;
      if (!ok || operand_a !== 4'(oa) || operand_b !== 4'(ob) || timer_sec !== 4'(m_reload)) begin
        failures++;
        $display("FAIL rand_round r%0d: ok=%b a=%0d b=%0d t=%0d want 1/%0d/%0d/%0d",
                 r, ok, operand_a, operand_b, timer_sec, oa, ob, m_reload);
      end
      mode = $urandom % 5;
      case (mode)
        0: begin
          submit(ex);
          right = 1'b1;
        end
        1: begin
          submit((ex + 1 + ($urandom % 31)) % 32);
          right = 1'b0;
        end
        2: begin
          do_ticks(m_reload);
          right = 1'b0;
        end
        3: begin
          do_ticks($urandom % m_reload);
          submit(ex);
          right = 1'b1;
        end
        default: begin
          do_ticks(m_reload - 1);
          right = 1'($urandom);
          ans = right ? ex : (ex + 1) % 32;
          tick_1s = 1'b1;
          submit(ans);
          tick_1s = 1'b0;
        end
      endcase
      model_judge(right);
      checks++;
      if (correct !== right || wrong !== !right || score !== 8'(m_score) ||
          lives !== 3'(m_lives)) begin
        failures++;
        $display("FAIL rand_judge r%0d m%0d: c=%b w=%b score=%0d lives=%0d want %b/%b/%0d/%0d",
                 r, mode, correct, wrong, score, lives, right, !right, m_score, m_lives);
      end
      if (m_lives == 0) begin
        @(negedge clk);
        checks++;
        if (game_over !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rand_game_over r%0d: go=%b busy=%b want 1/0", r, game_over, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    bit all_ok = 1'b1;
    op_sel = 1'b0;
    no_borrow = 1'b0;
    session_begin();
    for (int r = 0; r < 257; r++) begin
      play_round(r % 16, 15, 0, 0, 1'b0, ok);
      all_ok = all_ok && ok && (timer_sec == 4'(m_reload));
      submit((r % 16) + 15);
      model_judge(1'b1);
    end
    checks++;
    if (!all_ok || score !== 8'd255 || lives !== 3'd3) begin
      failures++;
      $display("FAIL score_saturate: ok=%b score=%0d lives=%0d want 1/255/3", all_ok, score, lives);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    session_begin();
    serve_operand(9, 0, ok);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({rng_req, operand_a, operand_b, timer_sec, score, lives, correct, wrong, busy,
         game_over} !== 31'd0) begin
      failures++;
      $display("FAIL reset_mid: got %h want 0", {rng_req, operand_a, operand_b, timer_sec,
               score, lives, correct, wrong, busy, game_over});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_swap();
    test_sub_wrap();
    test_timeout_game_over();
    test_answer_beats_timeout();
    test_abort();
`ifdef STREAK_SPEEDUP_EN
    test_streak();
`endif
    test_random();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
